// File: rtl/pipe_stage_fifo.sv
// ---------------------------------------------------------------------------
// pipe_stage_fifo
//   Small show-ahead FIFO placed between two CPU pipeline stages (or between
//   the core and a slow peripheral). It absorbs downstream stalls without
//   losing data, and flush_i clears it synchronously on a branch or exception.
//
// Ports
//   clk          rising-edge clock
//   rst_ni       asynchronous active-low reset
//   flush_i      synchronous clear of all entries (highest priority)
//   in_valid_i   upstream presents a word on in_data_i
//   in_ready_o   FIFO accepts a word this cycle (not full)
//   in_data_i    write data, WIDTH bits
//   out_valid_o  head entry valid (not empty)
//   out_ready_i  downstream consumes the head entry this cycle
//   out_data_o   head entry data; 0 when out_valid_o is low
//   count_o      occupancy, 0..DEPTH
//   full_o       count_o == DEPTH
//   empty_o      count_o == 0
//
// Handshake: a word moves on a rising edge where valid and ready are both
// high (push = in_valid_i & in_ready_o, pop = out_valid_o & out_ready_i).
// While valid is high and ready is low, the producer holds its data stable.
// in_ready_o and out_valid_o come only from registered state. There is no
// combinational path from out_ready_i to in_ready_o, nor from in_valid_i to
// out_valid_o.
// ---------------------------------------------------------------------------
module pipe_stage_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Status is decoded from the occupancy count. DEPTH is a power of two,
    // so the pointers wrap by plain overflow and never need a compare.
    assign full_o      = (count == CNT_FULL);
    assign empty_o     = (count == '0);
    assign in_ready_o  = ~full_o;
    assign out_valid_o = ~empty_o;
    assign count_o     = count;

    // The head is visible before it is consumed. It reads as zero when the
    // FIFO is empty, so stale storage never reaches the consumer.
    assign out_data_o  = out_valid_o ? mem[rd_ptr] : '0;

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush_i) begin
            // Any push or pop in the flush cycle is dropped. Storage keeps
            // its old values, but the output mux hides them.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data_i;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_fifo
//   Directed and randomized bench for pipe_stage_fifo with WIDTH=8, DEPTH=4.
//   The reference model is an ordinary queue of words. A push appends when
//   the queue holds fewer than DEPTH words, and a pop removes the front
//   word when the queue is non-empty. A flush or reset empties the queue.
//   All expected outputs are derived from the queue contents.
// ---------------------------------------------------------------------------
module tb_pipe_stage_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_ni;
    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] in_data_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] out_data_o;
    logic [CNT_W-1:0] count_o;
    logic             full_o;
    logic             empty_o;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard: words the FIFO should currently hold, oldest first.
    logic [WIDTH-1:0] exp_q[$];

    pipe_stage_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .count_o     (count_o),
        .full_o      (full_o),
        .empty_o     (empty_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every output with the value the queue model implies.
    task automatic check_all(input string tag);
        int          sz;
        logic [31:0] exp_data;
        sz       = exp_q.size();
        exp_data = (sz > 0) ? 32'(exp_q[0]) : 32'd0;
        check({tag, ".count"},     32'(count_o),     32'(sz));
        check({tag, ".in_ready"},  32'(in_ready_o),  32'(sz < DEPTH));
        check({tag, ".out_valid"}, 32'(out_valid_o), 32'(sz > 0));
        check({tag, ".full"},      32'(full_o),      32'(sz == DEPTH));
        check({tag, ".empty"},     32'(empty_o),     32'(sz == 0));
        check({tag, ".out_data"},  32'(out_data_o),  exp_data);
    endtask

    // ---------------- driver ----------------
    // The task is entered 1 time unit after a rising edge. It drives the
    // inputs, advances one edge, updates the model from the pre-edge queue,
    // and then checks the outputs 1 time unit after that edge.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r,
                        input logic f, input string tag, output logic accepted);
        int  sz;
        logic do_push;
        logic do_pop;
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = r;
        flush_i     = f;
        sz      = exp_q.size();
        do_push = v && (sz < DEPTH);
        do_pop  = r && (sz > 0);
        @(posedge clk);
        if (f) begin
            exp_q.delete();
            accepted = 1'b0;
        end else begin
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(d);
            accepted = do_push;
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b0;
        flush_i     = 1'b0;
    endtask

    // ---------------- sequence ----------------
    logic             acc;
    logic             pend;
    logic [WIDTH-1:0] cur_d;
    logic             cur_v;
    logic             cur_r;
    logic             cur_f;
    logic [WIDTH-1:0] fill_vals [4];

    initial begin
        fill_vals[0] = 8'h11;
        fill_vals[1] = 8'h22;
        fill_vals[2] = 8'h33;
        fill_vals[3] = 8'h44;

        // Power-on reset.
        idle_inputs();
        rst_ni = 1'b0;
        #12;
        check_all("por");
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_por");

        // 1: an asynchronous reset in the middle of a cycle.
        step(1'b1, 8'hC1, 1'b0, 1'b0, "pre_rst_a", acc);
        step(1'b1, 8'hC2, 1'b0, 1'b0, "pre_rst_b", acc);
        idle_inputs();
        #3;
        rst_ni = 1'b0;
        exp_q.delete();
        #1;
        check_all("async_rst");
        #2;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        check_all("after_rst");

        // 2: fill to full with out_ready_i low, then try a 5th push.
        foreach (fill_vals[i]) step(1'b1, fill_vals[i], 1'b0, 1'b0, "fill", acc);
        check("fill.count4", 32'(count_o), 32'd4);
        step(1'b1, 8'h55, 1'b0, 1'b0, "fill_held", acc);
        check("fill_held.rejected", 32'(acc), 32'd0);
        step(1'b1, 8'h55, 1'b0, 1'b0, "fill_held2", acc);
        check("fill.head", 32'(out_data_o), 32'h11);

        // 3: drain four words in order, then one extra pop on an empty FIFO.
        for (int i = 0; i < 4; i++) begin
            check("drain.order", 32'(out_data_o), 32'(fill_vals[i]));
            step(1'b0, 8'h00, 1'b1, 1'b0, "drain", acc);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, "drain_extra", acc);
        check("drain.empty", 32'(empty_o), 32'd1);

        // 4: streaming. Push 0x00, then push and pop together for 0x01..0x09.
        step(1'b1, 8'h00, 1'b0, 1'b0, "stream_first", acc);
        check("stream.latency", 32'(out_data_o), 32'h00);
        for (int i = 1; i < 10; i++) begin
            check("stream.order", 32'(out_data_o), 32'(i - 1));
            step(1'b1, 8'(i), 1'b1, 1'b0, "stream", acc);
            check("stream.count1", 32'(count_o), 32'd1);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, "stream_drain", acc);

        // 5: at full, a push in the same cycle as a pop is refused. The
        //    word is accepted one cycle later and comes out last.
        foreach (fill_vals[i]) step(1'b1, fill_vals[i], 1'b0, 1'b0, "fp_fill", acc);
        step(1'b1, 8'h55, 1'b1, 1'b0, "fp_pop", acc);
        check("fp.rejected", 32'(acc), 32'd0);
        check("fp.count3", 32'(count_o), 32'd3);
        step(1'b1, 8'h55, 1'b0, 1'b0, "fp_push", acc);
        check("fp.count4", 32'(count_o), 32'd4);
        for (int i = 1; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "fp_drain", acc);
        check("fp.last", 32'(out_data_o), 32'h55);
        step(1'b0, 8'h00, 1'b1, 1'b0, "fp_drain_last", acc);

        // 6: a flush while a push and a pop are also requested.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, "fl_fill", acc);
        step(1'b1, 8'h77, 1'b1, 1'b1, "flush", acc);
        check("flush.count0", 32'(count_o), 32'd0);
        step(1'b1, 8'hA5, 1'b0, 1'b0, "post_flush", acc);
        check("flush.first", 32'(out_data_o), 32'hA5);
        step(1'b0, 8'h00, 1'b1, 1'b0, "post_flush_pop", acc);

        // Random traffic. A stalled word is held until it is accepted.
        pend  = 1'b0;
        cur_d = '0;
        for (int n = 0; n < 400; n++) begin
            if (!pend) begin
                cur_v = ($urandom_range(0, 99) < 60);
                cur_d = 8'($urandom_range(0, 255));
            end
            cur_r = ($urandom_range(0, 99) < 50);
            cur_f = ($urandom_range(0, 99) < 4);
            step(cur_v, cur_d, cur_r, cur_f, "rand", acc);
            pend = cur_v && !acc && !cur_f;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
